// File: rtl/clas_pipe_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// Holds the opcode encoding and the default operand/segment widths.
package clas_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/clas_seg.sv
// Combinational SEG-bit carry-lookahead slice: every internal carry is
// formed directly from generate/propagate terms and c_in, not rippled.
module clas_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out,
    output logic           c_msb_in
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in, built as a sum of products
    always_comb begin
        logic prod;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (g[j] & prod);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (c_in & prod);
        end
    end

    assign sum      = p ^ c[SEG-1:0];
    assign c_out    = c[SEG];
    assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/clas_pipe.sv
// Pipelined add/subtract: one SEG-bit lookahead segment resolved per stage,
// operands travel alongside so every result bit of an operation exits together.
module clas_pipe
    import clas_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int STAGES = WIDTH / SEG;

    logic                          sub_op;
    logic [STAGES-1:0]             v_q, c_q, m_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, r_q;
    logic [STAGES-1:0]             src_v, src_c;
    logic [STAGES-1:0][WIDTH-1:0]  src_a, src_b, src_r, nxt_r;
    logic [STAGES-1:0][SEG-1:0]    seg_sum;
    logic [STAGES-1:0]             seg_cout, seg_cmsb;

    assign sub_op = (op_e'(sel) == OP_SUB);

    // Stage k consumes what stage k-1 registered; stage 0 takes the ports directly
    always_comb begin
        src_v = '0;
        src_c = '0;
        src_a = '0;
        src_b = '0;
        src_r = '0;
        src_v[0] = in_valid;
        src_c[0] = sub_op;
        src_a[0] = a;
        src_b[0] = b ^ {WIDTH{sub_op}};
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_r[k] = r_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        clas_seg #(.SEG(SEG)) u_seg (
            .a        (src_a[k][k*SEG +: SEG]),
            .b        (src_b[k][k*SEG +: SEG]),
            .c_in     (src_c[k]),
            .sum      (seg_sum[k]),
            .c_out    (seg_cout[k]),
            .c_msb_in (seg_cmsb[k])
        );
    end

    always_comb begin
        nxt_r = src_r;
        for (int k = 0; k < STAGES; k++) begin
            nxt_r[k][k*SEG +: SEG] = seg_sum[k];
        end
    end

    // A held output freezes every stage at once, so nothing can overtake it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= '0;
            c_q <= '0;
            m_q <= '0;
            a_q <= '0;
            b_q <= '0;
            r_q <= '0;
        end else if (in_ready) begin
            v_q <= src_v;
            c_q <= seg_cout;
            m_q <= seg_cmsb;
            a_q <= src_a;
            b_q <= src_b;
            r_q <= nxt_r;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign in_ready  = out_ready | ~out_valid;
    assign result    = r_q[STAGES-1];
    assign c_out     = c_q[STAGES-1];
    assign ovf       = c_q[STAGES-1] ^ m_q[STAGES-1];
    assign zero      = out_valid & ~|r_q[STAGES-1];
    assign neg       = r_q[STAGES-1][WIDTH-1];

endmodule

// File: tb/tb_clas_pipe.sv
// Self-checking bench for clas_pipe (WIDTH=32, SEG=8) against an arithmetic
// reference model with an in-order queue of expected results.
module tb_clas_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        c_out;
    logic        ovf;
    logic        zero;
    logic        neg;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   chk_lat = 1'b1;

    clas_pipe #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: plain unsigned/signed arithmetic on wide integers
    function automatic exp_t model(input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t       e;
        longint     sx;
        longint     sy;
        longint     sr;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            e.r = x + y;
            e.c = (longint'(x) + longint'(y)) > 64'sd4294967295;
            sr  = sx + sy;
        end else begin
            e.r = x - y;
            e.c = (x >= y);
            sr  = sx - sy;
        end
        e.v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z    = (e.r == 32'h0);
        e.n    = e.r[31];
        e.acc  = cyc;
        e.seen = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic iv, input logic s, input logic [31:0] aa,
                        input logic [31:0] bb, input logic ordy, output logic accepted);
        logic cons;
        in_valid  = iv;
        sel       = s;
        a         = aa;
        b         = bb;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready_rule", in_ready, out_ready || !out_valid);
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", out_valid, 1'b0);
            end else begin
                check("result", result, q[0].r);
                check("c_out", c_out, q[0].c);
                check("ovf", ovf, q[0].v);
                check("zero", zero, q[0].z);
                check("neg", neg, q[0].n);
                if (!q[0].seen && chk_lat) check("latency", cyc - q[0].acc, 4);
                q[0].seen = 1'b1;
            end
        end else if (q.size() > 0 && chk_lat && (cyc - q[0].acc) >= 4) begin
            check("late_valid", out_valid, 1'b1);
        end
        accepted = iv && in_ready;
        cons     = out_valid && ordy;
        @(posedge clk);
        if (cons) void'(q.pop_front());
        if (accepted) q.push_back(model(s, aa, bb));
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            idle(1);
            guard++;
        end
        check("drained", q.size(), 0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] op_a [8];
        logic [31:0] op_b [8];
        logic        op_s [8];
        int          idx;
        int          n;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        sel       = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_result", result, 32'h0);
        check("rst_flags", {c_out, ovf, zero, neg}, 4'b0000);
        reset_n = 1'b1;

        $display("[TB] directed add/sub corner cases");
        step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, acc);
        check("accept_after_reset", acc, 1'b1);
        idle(6);
        check("drained_add", q.size(), 0);
        step(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, acc);
        idle(6);
        step(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, acc);
        idle(6);
        check("drained_sub", q.size(), 0);

        $display("[TB] back-to-back random ops with mid-stream stall");
        for (int i = 0; i < 8; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
            op_s[i] = 1'($urandom_range(0, 1));
        end
        chk_lat = 1'b0;
        idx = 0;
        n   = 0;
        while (idx < 8 && n < 40) begin
            step(1'b1, op_s[idx], op_a[idx], op_b[idx], !(n >= 4 && n < 7), acc);
            if (acc) idx++;
            n++;
        end
        check("all_accepted", idx, 8);
        drain();
        chk_lat = 1'b1;

        $display("[TB] reset during flight");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, $urandom, 1'b1, acc);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_result", result, 32'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(6);
        step(1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, acc);
        check("accept_after_midrst", acc, 1'b1);
        idle(6);
        check("drained_rst", q.size(), 0);

        $display("[TB] bubbles with long carry chain");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b1, acc);
            idle(1);
            step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1, acc);
            idle(2);
        end
        drain();

        $display("[TB] random ops with random backpressure");
        chk_lat = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
